// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states, instruction field positions and opcode classification
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd9;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'd10;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd11;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd16;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'd19;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'd20;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_RR, K_IMM, K_UN, K_MD, K_MF, K_LD, K_ST, K_HALT
    } kind_t;

    function automatic kind_t op_kind(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:         return K_RR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return K_IMM;
            OP_NEG, OP_NOT:                  return K_UN;
            OP_MUL, OP_DIV:                  return K_MD;
            OP_MFHI, OP_MFLO:                return K_MF;
            OP_LD:                           return K_LD;
            OP_ST:                           return K_ST;
            OP_HALT:                         return K_HALT;
            default:                         return K_NOP;
        endcase
    endfunction

    function automatic logic [OPC_W-1:0] imm_alu(input logic [OPC_W-1:0] op);
        return op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : OP_ADD;
    endfunction
endpackage

// File: rtl/reg_decoder_4to16.sv
// reg_decoder_4to16: register index to one-hot enable vector, all zero when disabled
module reg_decoder_4to16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);
    assign onehot = en ? 16'(1) << idx : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute T-state control unit
module control_sequencer
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              read,
    output logic              write,
    output logic              Yin,
    output logic              Zin,
    output logic              Zhighout,
    output logic              Zlowout,
    output logic              HIin,
    output logic              LOin,
    output logic              HIout,
    output logic              LOout,
    output logic              Cout,
    output logic [OPC_W-1:0]  alu_op,
    output logic              run
);
    state_t           state;
    kind_t            kind;
    logic [OPC_W-1:0] op;
    logic [3:0]       ra, rb, rc, rout_idx;
    logic             rin_en, rout_en;
    logic             unused_c;

    assign op       = ir[OP_HI:OP_LO];
    assign ra       = ir[RA_HI:RA_LO];
    assign rb       = ir[RB_HI:RB_LO];
    assign rc       = ir[RC_HI:RC_LO];
    assign kind     = op_kind(op);
    assign unused_c = ^ir[RC_LO-1:0];

    // state sequencing; clear wins over every transition, including memory waits
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else begin
            case (state)
                S_IDLE:  state <= S_F0;
                S_F0:    state <= S_F1;
                S_F1:    state <= mem_ready ? S_F2 : S_F1;
                S_F2:    state <= S_T3;
                S_T3:    state <= kind == K_HALT ? S_HALT : (kind == K_NOP || kind == K_MF) ? S_F0 : S_T4;
                S_T4:    state <= kind == K_UN ? S_F0 : S_T5;
                S_T5:    state <= (kind == K_RR || kind == K_IMM) ? S_F0 : S_T6;
                S_T6:    state <= kind == K_MD ? S_F0 : (kind == K_LD && !mem_ready) ? S_T6 : S_T7;
                S_T7:    state <= (kind == K_ST && !mem_ready) ? S_T7 : S_F0;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore control word from state and instruction fields only
    always_comb begin
        {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write} = '0;
        {Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout} = '0;
        alu_op   = '0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb;
        run      = state != S_IDLE && state != S_HALT;
        case (state)
            S_F0: {PCout, MARin, IncPC} = 3'b111;
            S_F1: {read, MDRin} = 2'b11;
            S_F2: {MDRout, IRin} = 2'b11;
            S_T3: case (kind)
                K_RR, K_IMM, K_LD, K_ST: {rout_en, Yin} = 2'b11;
                K_UN: begin
                    {rout_en, Zin} = 2'b11;
                    alu_op = op;
                end
                K_MD: begin
                    {rout_en, Yin} = 2'b11;
                    rout_idx = ra;
                end
                K_MF: begin
                    HIout  = op == OP_MFHI;
                    LOout  = op == OP_MFLO;
                    rin_en = 1'b1;
                end
                default: ;
            endcase
            S_T4: case (kind)
                K_RR: begin
                    {rout_en, Zin} = 2'b11;
                    rout_idx = rc;
                    alu_op = op;
                end
                K_IMM: begin
                    {Cout, Zin} = 2'b11;
                    alu_op = imm_alu(op);
                end
                K_LD, K_ST: begin
                    {Cout, Zin} = 2'b11;
                    alu_op = OP_ADD;
                end
                K_UN: {Zlowout, rin_en} = 2'b11;
                K_MD: begin
                    {rout_en, Zin} = 2'b11;
                    alu_op = op;
                end
                default: ;
            endcase
            S_T5: case (kind)
                K_RR, K_IMM: {Zlowout, rin_en} = 2'b11;
                K_MD:        {Zlowout, LOin} = 2'b11;
                K_LD, K_ST:  {Zlowout, MARin} = 2'b11;
                default: ;
            endcase
            S_T6: case (kind)
                K_MD: {Zhighout, HIin} = 2'b11;
                K_LD: {read, MDRin} = 2'b11;
                K_ST: begin
                    {rout_en, MDRin} = 2'b11;
                    rout_idx = ra;
                end
                default: ;
            endcase
            S_T7: case (kind)
                K_LD: {MDRout, rin_en} = 2'b11;
                K_ST: {MDRout, write} = 2'b11;
                default: ;
            endcase
            default: ;
        endcase
    end

    reg_decoder_4to16 u_rin (
        .idx    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_decoder_4to16 u_rout (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream checked cycle by cycle against a per-instruction control-word model
module tb_control_sequencer;
    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [17:0] s;
        logic [4:0]  alu;
        logic        run;
    } cw_t;

    typedef struct {
        int  rdy;
        cw_t cw;
    } step_t;

    localparam logic [17:0] PCOUT  = 18'h20000;
    localparam logic [17:0] INCPC  = 18'h08000;
    localparam logic [17:0] IRIN   = 18'h04000;
    localparam logic [17:0] MARIN  = 18'h02000;
    localparam logic [17:0] MDRIN  = 18'h01000;
    localparam logic [17:0] MDROUT = 18'h00800;
    localparam logic [17:0] READ   = 18'h00400;
    localparam logic [17:0] WRITE  = 18'h00200;
    localparam logic [17:0] YIN    = 18'h00100;
    localparam logic [17:0] ZIN    = 18'h00080;
    localparam logic [17:0] ZHIGH  = 18'h00040;
    localparam logic [17:0] ZLOW   = 18'h00020;
    localparam logic [17:0] HIIN   = 18'h00010;
    localparam logic [17:0] LOIN   = 18'h00008;
    localparam logic [17:0] HIOUT  = 18'h00004;
    localparam logic [17:0] LOOUT  = 18'h00002;
    localparam logic [17:0] COUT   = 18'h00001;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout;
    logic [4:0]  alu_op;
    logic        run;
    cw_t         act;

    int          total = 0;
    int          bad = 0;
    step_t       q[$];
    cw_t         hist[$];
    logic [31:0] cur_ir;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .read(read), .write(write),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .alu_op(alu_op), .run(run)
    );

    always #5 clock = ~clock;

    assign act = {Rin, Rout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write,
                  Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, alu_op, run};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s ir=%h got=%h want=%h", nm, ir, got, want);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h1 << i;
    endfunction

    function automatic cw_t w(input logic [17:0] s, input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
        return {rin, rout, s, alu, 1'b1};
    endfunction

    // rdy: 0/1 drives mem_ready for that cycle, 2 means the value must not matter
    task automatic add(input int rdy, input cw_t cw);
        q.push_back('{rdy, cw});
    endtask

    // builds the full expected control-word sequence of one instruction
    task automatic plan(input logic [31:0] i, input int w1, input int w6);
        logic [4:0] op = i[31:27];
        logic [3:0] ra = i[26:23];
        logic [3:0] rb = i[22:19];
        logic [3:0] rc = i[18:15];
        q.delete();
        cur_ir = i;
        add(2, w(PCOUT | MARIN | INCPC, 0, 0, 0));
        repeat (w1) add(0, w(READ | MDRIN, 0, 0, 0));
        add(1, w(READ | MDRIN, 0, 0, 0));
        add(2, w(MDROUT | IRIN, 0, 0, 0));
        if (op >= 3 && op <= 11) begin
            add(2, w(YIN, 0, oh(rb), 0));
            add(2, w(ZIN, 0, oh(rc), op));
            add(2, w(ZLOW, oh(ra), 0, 0));
        end else if (op == 1 || (op >= 12 && op <= 14)) begin
            add(2, w(YIN, 0, oh(rb), 0));
            add(2, w(COUT | ZIN, 0, 0, op == 13 ? 5'd5 : op == 14 ? 5'd6 : 5'd3));
            add(2, w(ZLOW, oh(ra), 0, 0));
        end else if (op == 17 || op == 18) begin
            add(2, w(ZIN, 0, oh(rb), op));
            add(2, w(ZLOW, oh(ra), 0, 0));
        end else if (op == 15 || op == 16) begin
            add(2, w(YIN, 0, oh(ra), 0));
            add(2, w(ZIN, 0, oh(rb), op));
            add(2, w(ZLOW | LOIN, 0, 0, 0));
            add(2, w(ZHIGH | HIIN, 0, 0, 0));
        end else if (op == 19 || op == 20) begin
            add(2, w(op == 19 ? HIOUT : LOOUT, oh(ra), 0, 0));
        end else if (op == 0 || op == 2) begin
            add(2, w(YIN, 0, oh(rb), 0));
            add(2, w(COUT | ZIN, 0, 0, 5'd3));
            add(2, w(ZLOW | MARIN, 0, 0, 0));
            if (op == 0) begin
                repeat (w6) add(0, w(READ | MDRIN, 0, 0, 0));
                add(1, w(READ | MDRIN, 0, 0, 0));
                add(2, w(MDROUT, oh(ra), 0, 0));
            end else begin
                add(2, w(MDRIN, 0, oh(ra), 0));
                repeat (w6) add(0, w(MDROUT | WRITE, 0, 0, 0));
                add(1, w(MDROUT | WRITE, 0, 0, 0));
            end
        end else begin
            add(2, w(0, 0, 0, 0));
        end
    endtask

    // walks the planned sequence in lockstep with the DUT; stop >= 0 raises clear after that step
    task automatic run_q(input int stop);
        hist.delete();
        foreach (q[k]) begin
            @(negedge clock);
            if (k == 0) ir = cur_ir;
            mem_ready = (q[k].rdy == 2) ? 1'($urandom_range(0, 1)) : (q[k].rdy == 1);
            chk($sformatf("cw step=%0d", k), 64'(act), 64'(q[k].cw));
            chk("onehot", {62'd0, $onehot0(Rin), $onehot0(Rout)}, 64'd3);
            hist.push_back(act);
            if (k == stop) begin
                clear = 1'b1;
                return;
            end
        end
    endtask

    task automatic idle_after_clear();
        @(negedge clock);
        chk("idle", 64'(act), 64'd0);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] acc;
        repeat (2) begin
            @(negedge clock);
            chk("reset", 64'(act), 64'd0);
        end
        clear = 1'b0;

        plan(enc(3, 3, 1, 2), 0, 0);
        run_q(-1);
        chk("add_len", 64'(hist.size()), 64'd6);
        chk("add_f0", 64'(hist[0].s), 64'(PCOUT | MARIN | INCPC));
        chk("add_t3", 64'({hist[3].rout, hist[3].s}), 64'({16'h0002, YIN}));
        chk("add_t4", 64'({hist[4].rout, hist[4].s, hist[4].alu}), 64'({16'h0004, ZIN, 5'd3}));
        chk("add_t5", 64'({hist[5].rin, hist[5].s}), 64'({16'h0008, ZLOW}));

        plan(enc(0, 2, 1, 0) | 32'h10, 0, 3);
        run_q(-1);
        chk("ld_len", 64'(hist.size()), 64'd11);
        n = 0;
        for (int k = 6; k < 10; k++) n += ((hist[k].s & (READ | MDRIN)) == (READ | MDRIN)) ? 1 : 0;
        chk("ld_reads", 64'(n), 64'd4);
        chk("ld_t7", 64'(hist[10].rin), 64'h0004);

        plan(enc(16, 4, 5, 0), 0, 0);
        run_q(-1);
        acc = '0;
        foreach (hist[k]) acc |= hist[k].rin;
        chk("mul_t5", 64'(hist[5].s), 64'(ZLOW | LOIN));
        chk("mul_t6", 64'(hist[6].s), 64'(ZHIGH | HIIN));
        chk("mul_rin", 64'(acc), 64'd0);

        plan(enc(31, 7, 8, 9), 0, 0);
        run_q(-1);
        chk("unassigned_len", 64'(hist.size()), 64'd4);
        chk("unassigned_t3", 64'({hist[3].rin, hist[3].rout, hist[3].s}), 64'd0);

        plan(enc(2, 6, 7, 0) | 32'h5, 0, 5);
        run_q(8);
        idle_after_clear();

        for (int t = 0; t < 200; t++) begin
            int op = $urandom_range(0, 31);
            if (op == 27) op = 26;
            plan(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15))
                 | 32'($urandom_range(0, 32767)), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                run_q($urandom_range(0, q.size() - 1));
                idle_after_clear();
            end else begin
                run_q(-1);
            end
        end

        plan(enc(27, 0, 0, 0), 0, 0);
        repeat (20) add(2, '0);
        run_q(-1);
        clear = 1'b1;
        idle_after_clear();
        plan(enc(26, 0, 0, 0), 1, 0);
        run_q(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
